// File: rtl/fetch_classify.sv
// ----------------------------------------------------------------------------
// fetch_classify
//
// Front-end fetch-and-classify unit. Fetches one 32-bit instruction at a time
// from instruction memory, classifies its opcode into one-hot class strobes
// for control decode, and then computes the next fetch address from the
// next-PC select returned by control decode.
//
// Handshake: imem_req_o is a single-cycle request pulse carrying imem_addr_o.
// Memory answers later with imem_valid_i for one or more cycles. The word on
// imem_rdata_i is taken on the first WAIT-state edge with imem_valid_i high.
// A response during any other state is ignored. Downstream accepts the
// issued instruction on the first ISSUE edge with stall_i low. Until then
// every output holds.
//
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   imem_req_o      fetch request pulse (FETCH state only)
//   imem_addr_o     fetch address, always equal to pc_o
//   imem_valid_i    memory response valid
//   imem_rdata_i    memory response data
//   stall_i         downstream holds the issued instruction
//   nextpc_sel_i    00 seq, 01 branch, 10 jal, 11 jalr
//   branch_taken_i  branch outcome
//   jalr_target_i   rs1+imm from the ALU
//   pc_o            PC of the current instruction
//   inst_o          latched instruction word
//   inst_valid_o    instruction and strobes valid (ISSUE state)
//   r_type_o .. lui_o  one-hot class strobes
//   fault_o         sticky fault (illegal opcode or misaligned target)
//   dbg_state_o     current FSM state, for observation only
// ----------------------------------------------------------------------------
module fetch_classify #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic [1:0]  nextpc_sel_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jalr_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        r_type_o,
    output logic        load_o,
    output logic        store_o,
    output logic        branch_o,
    output logic        i_type_o,
    output logic        jalr_o,
    output logic        jal_o,
    output logic        lui_o,
    output logic        fault_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    // Class vector bit order: {r, load, store, branch, i, jalr, jal, lui}
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [7:0]  class_q, class_d;
    logic        fault_q, fault_d;

    logic [7:0]  dec_class;
    logic [31:0] b_imm;
    logic [31:0] j_imm;
    logic [31:0] next_pc;
    logic        issuing;

    // Opcode decode of the incoming memory word. Every legal opcode ends in
    // 2'b11, so a word with inst[1:0] != 11 decodes to all zeros (illegal).
    always_comb begin
        dec_class = 8'b0;
        case (imem_rdata_i[6:0])
            OP_R:      dec_class = 8'b1000_0000;
            OP_LOAD:   dec_class = 8'b0100_0000;
            OP_STORE:  dec_class = 8'b0010_0000;
            OP_BRANCH: dec_class = 8'b0001_0000;
            OP_I:      dec_class = 8'b0000_1000;
            OP_JALR:   dec_class = 8'b0000_0100;
            OP_JAL:    dec_class = 8'b0000_0010;
            OP_LUI:    dec_class = 8'b0000_0001;
            default:   dec_class = 8'b0;
        endcase
    end

    // Immediates come from the latched word, so they are stable in ISSUE.
    assign b_imm = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                    inst_q[11:8], 1'b0};
    assign j_imm = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                    inst_q[30:21], 1'b0};

    // The select is obeyed as given, whatever the instruction class is.
    always_comb begin
        next_pc = pc_q + 32'd4;
        case (nextpc_sel_i)
            2'b00:   next_pc = pc_q + 32'd4;
            2'b01:   next_pc = branch_taken_i ? (pc_q + b_imm) : (pc_q + 32'd4);
            2'b10:   next_pc = pc_q + j_imm;
            2'b11:   next_pc = jalr_target_i & 32'hFFFF_FFFE;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        class_d = class_q;
        fault_d = fault_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (imem_valid_i) begin
                    inst_d  = imem_rdata_i;
                    class_d = dec_class;
                    if (dec_class != 8'b0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                if (!stall_i) begin
                    // A target with bit1 set can never be fetched: halt and
                    // keep the PC of the instruction that produced it.
                    if (next_pc[1]) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            class_q <= 8'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            class_q <= class_d;
            fault_q <= fault_d;
        end
    end

    // Strobes are held in class_q but only shown while issuing.
    assign issuing      = (state_q == S_ISSUE);
    assign imem_req_o   = (state_q == S_FETCH);
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = issuing;
    assign r_type_o     = issuing & class_q[7];
    assign load_o       = issuing & class_q[6];
    assign store_o      = issuing & class_q[5];
    assign branch_o     = issuing & class_q[4];
    assign i_type_o     = issuing & class_q[3];
    assign jalr_o       = issuing & class_q[2];
    assign jal_o        = issuing & class_q[1];
    assign lui_o        = issuing & class_q[0];
    assign fault_o      = fault_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fetch_classify.sv
module tb_fetch_classify;

  logic        clk;
  logic        rst_ni;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic [1:0]  nextpc_sel_i;
  logic        branch_taken_i;
  logic [31:0] jalr_target_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        r_type_o, load_o, store_o, branch_o, i_type_o, jalr_o, jal_o, lui_o;
  logic        fault_o;
  logic [2:0]  dbg_state;
  logic [7:0]  strobes;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  bit          m_halted;

  // Legal opcodes, in strobe order r, load, store, branch, i, jalr, jal, lui
  logic [6:0] opc_tab [8] = '{7'h33, 7'h03, 7'h23, 7'h63, 7'h13, 7'h67, 7'h6F, 7'h37};

  fetch_classify dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_valid_i   (imem_valid_i),
    .imem_rdata_i   (imem_rdata_i),
    .stall_i        (stall_i),
    .nextpc_sel_i   (nextpc_sel_i),
    .branch_taken_i (branch_taken_i),
    .jalr_target_i  (jalr_target_i),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .inst_valid_o   (inst_valid_o),
    .r_type_o       (r_type_o),
    .load_o         (load_o),
    .store_o        (store_o),
    .branch_o       (branch_o),
    .i_type_o       (i_type_o),
    .jalr_o         (jalr_o),
    .jal_o          (jal_o),
    .lui_o          (lui_o),
    .fault_o        (fault_o),
    .dbg_state_o    (dbg_state)
  );

  assign strobes = {r_type_o, load_o, store_o, branch_o, i_type_o, jalr_o, jal_o, lui_o};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] m_class(input logic [31:0] w);
    logic [7:0] c;
    c = 8'h0;
    for (int i = 0; i < 8; i++)
      if (w[6:0] == opc_tab[i]) c[7-i] = 1'b1;
    return c;
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [31:0] w,
                                         input logic [1:0] sel, input bit taken,
                                         input logic [31:0] tgt);
    int bimm;
    int jimm;
    bimm = int'({w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 4096 : 0);
    jimm = int'({w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? (1 << 20) : 0);
    case (sel)
      2'd0: return pc + 32'd4;
      2'd1: return taken ? pc + 32'(bimm) : pc + 32'd4;
      2'd2: return pc + 32'(jimm);
      default: return tgt - (tgt % 2);
    endcase
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_ivalid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_strobes", {24'h0, strobes}, 32'h0);
    chk("rst_fault", {31'h0, fault_o}, 32'h0);
  endtask

  // ---------------- driver tasks ----------------
  // Asserts reset at the next falling edge, releases just after a rising
  // edge, then expects one IDLE cycle followed by a request at RESET_PC.
  task automatic reset_release();
    @(negedge clk);
    rst_ni = 1'b0;
    imem_valid_i = 1'b0;
    stall_i = 1'b0;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    m_pc = 32'h0;
    m_halted = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'h0, imem_req_o}, 32'h0);
    chk("idle_ivalid", {31'h0, inst_valid_o}, 32'h0);
    @(negedge clk);
    chk("first_req", {31'h0, imem_req_o}, 32'h1);
    chk("first_addr", imem_addr_o, 32'h0);
  endtask

  task automatic halt_checks();
    for (int k = 0; k < 3; k++) begin
      chk("halt_fault", {31'h0, fault_o}, 32'h1);
      chk("halt_ivalid", {31'h0, inst_valid_o}, 32'h0);
      chk("halt_strobes", {24'h0, strobes}, 32'h0);
      chk("halt_req", {31'h0, imem_req_o}, 32'h0);
      imem_valid_i = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      @(negedge clk);
    end
    imem_valid_i = 1'b0;
    m_halted = 1'b1;
  endtask

  // Called at the falling edge of a FETCH cycle. Answers after lat cycles,
  // optionally with a junk response during FETCH itself, then issues with
  // the given select after the given number of stall cycles.
  task automatic fetch_issue(input logic [31:0] word, input int lat, input bit junk,
                             input logic [1:0] sel, input bit taken,
                             input logic [31:0] tgt, input int stalls);
    logic [7:0]  cls;
    logic [31:0] nxt;
    cls = m_class(word);
    chk("fetch_req", {31'h0, imem_req_o}, 32'h1);
    chk("fetch_addr", imem_addr_o, m_pc);
    chk("fetch_pc", pc_o, m_pc);
    imem_valid_i = junk && (lat > 1);
    imem_rdata_i = 32'hFFFF_FFFF;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("wait_req", {31'h0, imem_req_o}, 32'h0);
      imem_valid_i = 1'b0;
      imem_rdata_i = $urandom;
    end
    @(negedge clk);
    chk("wait_ivalid", {31'h0, inst_valid_o}, 32'h0);
    imem_valid_i = 1'b1;
    imem_rdata_i = word;
    @(negedge clk);
    imem_valid_i = 1'b0;
    imem_rdata_i = $urandom;
    chk("inst_latched", inst_o, word);
    chk("issue_req", {31'h0, imem_req_o}, 32'h0);
    if (cls == 8'h0) begin
      halt_checks();
      return;
    end
    chk("issue_ivalid", {31'h0, inst_valid_o}, 32'h1);
    chk("issue_strobes", {24'h0, strobes}, {24'h0, cls});
    chk("issue_fault", {31'h0, fault_o}, 32'h0);
    chk("issue_pc", pc_o, m_pc);
    for (int s = 0; s < stalls; s++) begin
      stall_i = 1'b1;
      nextpc_sel_i = 2'($urandom_range(0, 3));
      branch_taken_i = 1'($urandom_range(0, 1));
      jalr_target_i = $urandom;
      imem_valid_i = 1'($urandom_range(0, 1));
      imem_rdata_i = $urandom;
      @(negedge clk);
      chk("stall_ivalid", {31'h0, inst_valid_o}, 32'h1);
      chk("stall_strobes", {24'h0, strobes}, {24'h0, cls});
      chk("stall_inst", inst_o, word);
      chk("stall_pc", pc_o, m_pc);
      chk("stall_req", {31'h0, imem_req_o}, 32'h0);
    end
    stall_i = 1'b0;
    imem_valid_i = 1'b0;
    nextpc_sel_i = sel;
    branch_taken_i = taken;
    jalr_target_i = tgt;
    nxt = m_next(m_pc, word, sel, taken, tgt);
    @(negedge clk);
    nextpc_sel_i = 2'($urandom_range(0, 3));
    jalr_target_i = $urandom;
    if (nxt[1]) begin
      chk("misalign_pc", pc_o, m_pc);
      halt_checks();
    end else begin
      chk("next_req", {31'h0, imem_req_o}, 32'h1);
      chk("next_addr", imem_addr_o, nxt);
      chk("next_ivalid", {31'h0, inst_valid_o}, 32'h0);
      chk("next_strobes", {24'h0, strobes}, 32'h0);
      m_pc = nxt;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] w;
    logic [31:0] r;
    logic [31:0] t;
    rst_ni = 1'b0;
    imem_valid_i = 1'b0;
    imem_rdata_i = 32'h0;
    stall_i = 1'b0;
    nextpc_sel_i = 2'b00;
    branch_taken_i = 1'b0;
    jalr_target_i = 32'h0;
    m_pc = 32'h0;
    m_halted = 1'b0;

    repeat (2) @(negedge clk);
    reset_release();

    // sequential fetch of addi
    fetch_issue(32'h0050_0093, 2, 1'b1, 2'b00, 1'b0, 32'h0, 0);
    // jalr to 0x10 (bit0 of target cleared)
    fetch_issue(32'h0000_8067, 1, 1'b0, 2'b11, 1'b0, 32'h0000_0011, 0);
    // beq -4 taken from 0x10
    fetch_issue(32'hFE00_0EE3, 1, 1'b0, 2'b01, 1'b1, 32'h0, 0);
    // back to 0x10, then beq not taken
    fetch_issue(32'h0000_8067, 3, 1'b1, 2'b11, 1'b0, 32'h0000_0011, 0);
    fetch_issue(32'hFE00_0EE3, 1, 1'b0, 2'b01, 1'b0, 32'h0, 0);
    // three stall cycles with toggling select; release value picks 0xFFFF_FFFC
    fetch_issue(32'h0040_006F, 2, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFD, 3);
    // wrap around
    fetch_issue(32'h0000_0033, 1, 1'b0, 2'b00, 1'b0, 32'h0, 0);
    // jalr 0x101 -> 0x100
    fetch_issue(32'h0000_8067, 1, 1'b0, 2'b11, 1'b0, 32'h0000_0101, 0);
    // reset in the WAIT cycle of the fetch at 0x100
    reset_release();

    // randomized instruction stream
    for (int it = 0; it < 40; it++) begin
      if (m_halted) reset_release();
      r = $urandom;
      if ($urandom_range(0, 9) == 0) w = r;
      else w = {r[31:7], opc_tab[$urandom_range(0, 7)]};
      t = $urandom;
      if ($urandom_range(0, 3) != 0) t[1] = 1'b0;
      fetch_issue(w, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t,
                  $urandom_range(0, 2));
    end
    if (m_halted) reset_release();

    // misaligned jalr target -> HALT
    fetch_issue(32'h0000_8067, 1, 1'b0, 2'b11, 1'b0, 32'h0000_0102, 0);
    chk("jalr_halted", {31'h0, m_halted}, 32'h1);
    reset_release();

    // illegal opcode -> HALT
    fetch_issue(32'hFFFF_FFFF, 2, 1'b0, 2'b00, 1'b0, 32'h0, 0);
    chk("illegal_pc", pc_o, 32'h0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
